mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/mem_arbiter_fifo.sv | 59 +++++
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port SDRAM arbiter: FSM state, owner id and read-tracking entry.
package mem_arbiter_pkg;

    // Tracking entries are sized for the widest burst counter this codebase uses.
    localparam int CNT_W = 16;

    typedef enum logic {
        IDLE     = 1'b0,
        WR_BURST = 1'b1
    } state_t;

    typedef logic owner_t;

    typedef struct packed {
        owner_t           id;
        logic [CNT_W-1:0] count;
    } track_t;

    // A zero burst count still moves one beat.
    function automatic logic [CNT_W-1:0] burst_beats(input logic [CNT_W-1:0] bc);
        return (bc == '0) ? CNT_W'(1) : bc;
    endfunction

endpackage

// File: rtl/mem_arbiter_fifo.sv
// Read-burst tracking FIFO: holds {owner, beats remaining}; the head counts down per returned
// beat and pops on its last beat.
module mem_arbiter_fifo
    import mem_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rest,
    input  logic   push,
    input  track_t push_entry,
    input  logic   beat,
    output track_t head,
    output logic   full,
    output logic   empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    track_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   used;
    logic          do_push;
    logic          do_beat;
    logic          pop;

    assign head    = mem[rd_ptr];
    assign empty   = (used == '0);
    assign full    = (used == (PW+1)'(DEPTH));
    // full is the registered flag, so a full FIFO that pops this cycle still refuses a push
    assign do_push = push && !full;
    assign do_beat = beat && !empty;
    assign pop     = do_beat && (mem[rd_ptr].count == CNT_W'(1));

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            else if (do_beat)
                mem[rd_ptr].count <= mem[rd_ptr].count - CNT_W'(1);
            case ({do_push, pop})
                2'b10:   used <= used + (PW+1)'(1);
                2'b01:   used <= used - (PW+1)'(1);
                default: used <= used;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (dcache s0, icache s1) arbiter onto one SDRAM master port with zero-latency command
// muxing and in-order read return routing. Define MEM_ARBITER_RR_EN for round-robin ties.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int BURST_W     = 8,
    parameter int OUTSTANDING = 4
) (
    input  logic               clk,
    input  logic               rest,

    input  logic [31:0]        s0_address,
    input  logic [3:0]         s0_byteEnable,
    input  logic               s0_read,
    input  logic               s0_write,
    input  logic [31:0]        s0_writeData,
    input  logic               s0_beginBurstTransfer,
    input  logic [BURST_W-1:0] s0_burstCount,
    output logic [31:0]        s0_readData,
    output logic               s0_readDataValid,
    output logic               s0_waitRequest,

    input  logic [31:0]        s1_address,
    input  logic [3:0]         s1_byteEnable,
    input  logic               s1_read,
    input  logic               s1_write,
    input  logic [31:0]        s1_writeData,
    input  logic               s1_beginBurstTransfer,
    input  logic [BURST_W-1:0] s1_burstCount,
    output logic [31:0]        s1_readData,
    output logic               s1_readDataValid,
    output logic               s1_waitRequest,

    output logic [31:0]        m0_address,
    output logic [3:0]         m0_byteEnable,
    output logic               m0_read,
    output logic               m0_write,
    output logic [31:0]        m0_writeData,
    output logic               m0_beginBurstTransfer,
    output logic [BURST_W-1:0] m0_burstCount,
    input  logic [31:0]        m0_readData,
    input  logic               m0_readDataValid,
    input  logic               m0_waitRequest,

    output logic               err_stray
);

    state_t             state;
    owner_t             owner;
    owner_t             sel;
    owner_t             tie_win;
    logic [BURST_W-1:0] beat_cnt;
    logic               req0, req1;
    logic               sel_read, sel_write, sel_begin;
    logic [BURST_W-1:0] sel_bc;
    logic               rd_acc, wr_acc;
    logic               fifo_full, fifo_empty;
    track_t             head, push_entry;

    assign req0 = s0_read | s0_write;
    assign req1 = s1_read | s1_write;

`ifdef MEM_ARBITER_RR_EN
    // Reset value lets s0 take the first tie after reset.
    owner_t last_grant;
    always_ff @(posedge clk or posedge rest) begin
        if (rest)
            last_grant <= 1'b1;
        else if (rd_acc || wr_acc)
            last_grant <= sel;
    end
    assign tie_win = ~last_grant;
`else
    assign tie_win = 1'b0;
`endif

    // IDLE picks combinationally so the command reaches m0 in the same cycle; WR_BURST is locked.
    always_comb begin
        sel = owner;
        if (state == IDLE) begin
            if (req0 && req1) sel = tie_win;
            else if (req1)    sel = 1'b1;
            else if (req0)    sel = 1'b0;
        end
    end

    assign sel_read  = sel ? s1_read  : s0_read;
    assign sel_write = sel ? s1_write : s0_write;
    assign sel_begin = sel ? s1_beginBurstTransfer : s0_beginBurstTransfer;
    assign sel_bc    = sel ? s1_burstCount : s0_burstCount;

    assign m0_address    = sel ? s1_address    : s0_address;
    assign m0_byteEnable = sel ? s1_byteEnable : s0_byteEnable;
    assign m0_writeData  = sel ? s1_writeData  : s0_writeData;
    assign m0_burstCount = sel_bc;
    // Reads are held off the bus while every tracking slot is taken.
    assign m0_read       = !rest && sel_read && !fifo_full;
    assign m0_write      = !rest && sel_write;
    assign m0_beginBurstTransfer = sel_begin && (m0_read || m0_write);

    assign rd_acc = m0_read  && !m0_waitRequest;
    assign wr_acc = m0_write && !m0_waitRequest;

    assign s0_waitRequest = rest || sel || m0_waitRequest || (s0_read && fifo_full);
    assign s1_waitRequest = rest || !sel || m0_waitRequest || (s1_read && fifo_full);

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            state    <= IDLE;
            owner    <= 1'b0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) owner <= sel;
                    if (wr_acc && (sel_bc > BURST_W'(1))) begin
                        state    <= WR_BURST;
                        beat_cnt <= sel_bc - BURST_W'(1);
                    end
                end
                WR_BURST: begin
                    if (wr_acc) begin
                        beat_cnt <= beat_cnt - BURST_W'(1);
                        if (beat_cnt == BURST_W'(1)) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign push_entry.id    = sel;
    assign push_entry.count = burst_beats(CNT_W'(sel_bc));

    mem_arbiter_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_fifo (
        .clk        (clk),
        .rest       (rest),
        .push       (rd_acc),
        .push_entry (push_entry),
        .beat       (m0_readDataValid),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Return path is a pure fan-out plus a head-id decode; beats with nothing tracked are flagged.
    assign s0_readData      = m0_readData;
    assign s1_readData      = m0_readData;
    assign s0_readDataValid = !rest && m0_readDataValid && !fifo_empty && (head.id == 1'b0);
    assign s1_readDataValid = !rest && m0_readDataValid && !fifo_empty && (head.id == 1'b1);
    assign err_stray        = !rest && m0_readDataValid && fifo_empty;

endmodule
